// File: rtl/enc_pkg.sv
// Shared types and default widths for the key-derivation / stream-encryption block.
//   state_t : controller states (IDLE, REDUCE, KEYED, ERR)
//   ENC_DW  : width of the dividend, data words and ciphertext
//   ENC_MW  : width of the modulus and of the derived key
//   ENC_CW  : width of the encrypted-word counter
package enc_pkg;

  localparam int ENC_DW = 64;
  localparam int ENC_MW = 32;
  localparam int ENC_CW = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REDUCE = 2'd1,
    KEYED  = 2'd2,
    ERR    = 2'd3
  } state_t;

endpackage

// File: rtl/mod_reduce_seq.sv
// Bit-serial restoring reducer: computes exp mod p, one dividend bit per cycle.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   load     : capture exp/p, clear remainder and iteration counter, start running
//   exp      : DW-bit dividend (sampled on load)
//   p        : MW-bit modulus, must be non-zero (sampled on load)
//   done     : combinational, high during the final (DW-th) iteration
//   rem      : combinational next remainder; equals exp mod p while done is high
module mod_reduce_seq
  import enc_pkg::*;
#(
  parameter int DW = ENC_DW,
  parameter int MW = ENC_MW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [DW-1:0] exp,
  input  logic [MW-1:0] p,
  output logic          done,
  output logic [MW-1:0] rem
);

  localparam int IW = $clog2(DW + 1);

  logic [DW-1:0] sh_q, sh_d;
  logic [MW-1:0] rem_q, rem_d;
  logic [MW-1:0] p_q, p_d;
  logic [IW-1:0] cnt_q, cnt_d;
  logic          run_q, run_d;
  logic [MW:0]   shifted;

  always_comb begin
    sh_d    = sh_q;
    rem_d   = rem_q;
    p_d     = p_q;
    cnt_d   = cnt_q;
    run_d   = run_q;
    done    = 1'b0;
    // The shifted-in remainder needs MW+1 bits: it can reach 2p-1 before the
    // conditional subtract, so compare and subtract happen at full width.
    shifted = {rem_q, sh_q[DW-1]};
    if (load) begin
      sh_d  = exp;
      rem_d = '0;
      p_d   = p;
      cnt_d = '0;
      run_d = 1'b1;
    end else if (run_q) begin
      sh_d  = sh_q << 1;
      rem_d = (shifted >= {1'b0, p_q}) ? MW'(shifted - {1'b0, p_q}) : shifted[MW-1:0];
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == IW'(DW - 1)) begin
        done  = 1'b1;
        run_d = 1'b0;
      end
    end
  end

  assign rem = rem_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_q  <= '0;
      rem_q <= '0;
      p_q   <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else begin
      sh_q  <= sh_d;
      rem_q <= rem_d;
      p_q   <= p_d;
      cnt_q <= cnt_d;
      run_q <= run_d;
    end
  end

endmodule

// File: rtl/enc_modxor_stream.sv
// Key derivation (exp mod p via mod_reduce_seq) followed by XOR stream encryption.
// Ports:
//   clk, rst                : clock, asynchronous active-high reset
//   start / start_ready     : key-derivation request; exp and p sampled on acceptance
//   exp, p                  : dividend and modulus
//   busy                    : reduction in progress
//   key_valid, key_o        : derived key and its qualifier
//   err                     : sticky divide-by-zero flag, cleared by next accepted start
//   din_valid/ready/data    : plaintext stream in
//   dout_valid/ready/data   : ciphertext stream out (single output register)
//   blk_cnt                 : words encrypted since last key load, wraps silently
//   dbg_state               : current controller state
//
// Handshakes: a transfer happens on a rising edge where valid and ready are both
// high. Valid, once raised, holds with stable data until the transfer; ready may
// depend combinationally on the consumer's ready but never on valid.
module enc_modxor_stream
  import enc_pkg::*;
#(
  parameter int DW = ENC_DW,
  parameter int MW = ENC_MW,
  parameter int CW = ENC_CW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          start_ready,
  input  logic [DW-1:0] exp,
  input  logic [MW-1:0] p,
  output logic          busy,
  output logic          key_valid,
  output logic [MW-1:0] key_o,
  output logic          err,
  input  logic          din_valid,
  output logic          din_ready,
  input  logic [DW-1:0] din_data,
  output logic          dout_valid,
  input  logic          dout_ready,
  output logic [DW-1:0] dout_data,
  output logic [CW-1:0] blk_cnt,
  output state_t        dbg_state
);

  state_t        state_q, state_d;
  logic [MW-1:0] key_q, key_d;
  logic [DW-1:0] dout_data_q, dout_data_d;
  logic          dout_valid_q, dout_valid_d;
  logic [CW-1:0] blk_cnt_q, blk_cnt_d;
  logic          err_q, err_d;

  logic          start_acc;
  logic          din_hs;
  logic          red_load;
  logic          red_done;
  logic [MW-1:0] red_rem;

  mod_reduce_seq #(
    .DW(DW),
    .MW(MW)
  ) u_reduce (
    .clk  (clk),
    .rst  (rst),
    .load (red_load),
    .exp  (exp),
    .p    (p),
    .done (red_done),
    .rem  (red_rem)
  );

  always_comb begin
    state_d      = state_q;
    key_d        = key_q;
    dout_data_d  = dout_data_q;
    dout_valid_d = dout_valid_q;
    blk_cnt_d    = blk_cnt_q;
    err_d        = err_q;
    red_load     = 1'b0;
    start_ready  = 1'b0;

    case (state_q)
      IDLE, ERR: start_ready = 1'b1;
      // Re-keying is only allowed once the output register has drained, so no
      // ciphertext produced under the old key is left stranded.
      KEYED:     start_ready = !dout_valid_q;
      default:   start_ready = 1'b0;
    endcase

    start_acc = start && start_ready;
    // A start accepted in KEYED wins over plaintext in the same cycle.
    din_ready = (state_q == KEYED) && !start_acc && (!dout_valid_q || dout_ready);
    din_hs    = din_valid && din_ready;

    if (start_acc) begin
      if (p == '0) begin
        state_d = ERR;
        err_d   = 1'b1;
      end else begin
        state_d   = REDUCE;
        err_d     = 1'b0;
        red_load  = 1'b1;
        blk_cnt_d = '0;
      end
    end else if ((state_q == REDUCE) && red_done) begin
      key_d     = red_rem;
      blk_cnt_d = '0;
      state_d   = KEYED;
    end

    // Single output register: a new word may replace a retiring one on the same edge.
    if (din_hs) begin
      dout_data_d  = din_data ^ DW'(key_q);
      dout_valid_d = 1'b1;
      blk_cnt_d    = blk_cnt_q + 1'b1;
    end else if (dout_ready) begin
      dout_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      key_q        <= '0;
      dout_data_q  <= '0;
      dout_valid_q <= 1'b0;
      blk_cnt_q    <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      key_q        <= key_d;
      dout_data_q  <= dout_data_d;
      dout_valid_q <= dout_valid_d;
      blk_cnt_q    <= blk_cnt_d;
      err_q        <= err_d;
    end
  end

  assign busy       = (state_q == REDUCE);
  assign key_valid  = (state_q == KEYED);
  assign key_o      = key_q;
  assign err        = err_q;
  assign dout_valid = dout_valid_q;
  assign dout_data  = dout_data_q;
  assign blk_cnt    = blk_cnt_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_enc_modxor_stream.sv
// Self-checking bench for enc_modxor_stream: key table, random keys against an
// arithmetic model, encryption streams with a scoreboard, error and reset cases.
module tb_enc_modxor_stream;
  import enc_pkg::*;

  localparam int DW = 64;
  localparam int MW = 32;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          start_ready;
  logic [DW-1:0] exp_i = '0;
  logic [MW-1:0] p_i = '0;
  logic          busy;
  logic          key_valid;
  logic [MW-1:0] key_o;
  logic          err;
  logic          din_valid = 1'b0;
  logic          din_ready;
  logic [DW-1:0] din_data = '0;
  logic          dout_valid;
  logic          dout_ready = 1'b0;
  logic [DW-1:0] dout_data;
  logic [CW-1:0] blk_cnt;
  state_t        dbg_state;

  int total = 0;
  int bad = 0;
  int overlap = 0;

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  always @(negedge clk) if (busy && key_valid) overlap++;

  enc_modxor_stream #(.DW(DW), .MW(MW), .CW(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .start_ready(start_ready),
    .exp        (exp_i),
    .p          (p_i),
    .busy       (busy),
    .key_valid  (key_valid),
    .key_o      (key_o),
    .err        (err),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .din_data   (din_data),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .dout_data  (dout_data),
    .blk_cnt    (blk_cnt),
    .dbg_state  (dbg_state)
  );

  typedef struct {
    logic [DW-1:0] e;
    logic [MW-1:0] pp;
    logic [MW-1:0] k;
  } vec_t;

  vec_t vecs[6];

  // reference model: plain modulo arithmetic
  function automatic logic [MW-1:0] ref_mod(input logic [DW-1:0] e, input logic [MW-1:0] pp);
    logic [DW-1:0] r;
    r = e % DW'(pp);
    return r[MW-1:0];
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  // driver: request a key and measure the latency to key_valid
  task automatic do_key(input logic [DW-1:0] e, input logic [MW-1:0] pp,
                        input logic [MW-1:0] k, input string nm);
    int n;
    @(negedge clk);
    start = 1'b1;
    exp_i = e;
    p_i   = pp;
    @(negedge clk);
    start = 1'b0;
    exp_i = {$urandom, $urandom};
    p_i   = $urandom;
    chk($sformatf("%s_accept", nm), 64'({busy, key_valid, err}), 64'(3'b100));
    n = 0;
    while (!key_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("%s_latency", nm), 64'(n), 64'(DW));
    chk($sformatf("%s_key", nm), 64'(key_o), 64'(k));
    chk($sformatf("%s_blk0", nm), 64'(blk_cnt), 64'(0));
  endtask

  // driver + scoreboard: stream nwords through the encryptor
  task automatic do_stream(input bit toggle, input int nwords, input logic [MW-1:0] k,
                           input int blk_exp, input string nm);
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] want;
    int sent;
    int rcv;
    int cyc;
    sent = 0;
    rcv  = 0;
    cyc  = 0;
    while (rcv < nwords && cyc < 200) begin
      @(negedge clk);
      dout_ready = toggle ? (cyc % 2 == 0) : 1'b1;
      din_valid  = (sent < nwords);
      din_data   = {$urandom, $urandom};
      #1;
      if (dout_valid && dout_ready) begin
        if (exp_q.size() == 0) begin
          chk($sformatf("%s_extra_word", nm), 64'(1), 64'(0));
        end else begin
          want = exp_q.pop_front();
          chk($sformatf("%s_word%0d", nm, rcv), dout_data, want);
        end
        rcv++;
      end
      if (din_valid && din_ready) begin
        exp_q.push_back(din_data ^ DW'(k));
        sent++;
      end
      cyc++;
    end
    din_valid = 1'b0;
    chk($sformatf("%s_sent", nm), 64'(sent), 64'(nwords));
    chk($sformatf("%s_rcvd", nm), 64'(rcv), 64'(nwords));
    chk($sformatf("%s_blk", nm), 64'(blk_cnt), 64'(blk_exp));
    if (!toggle) chk($sformatf("%s_cycles", nm), 64'(cyc), 64'(nwords + 1));
    dout_ready = 1'b1;
    @(negedge clk);
    chk($sformatf("%s_drained", nm), 64'(dout_valid), 64'(0));
    dout_ready = 1'b0;
  endtask

  initial begin
    logic [DW-1:0] e;
    logic [MW-1:0] pp;

    vecs[0] = '{e: 64'd100, pp: 32'd7, k: 32'd2};
    vecs[1] = '{e: 64'hFFFF_FFFF_FFFF_FFFF, pp: 32'hFFFF_FFFF, k: 32'd0};
    vecs[2] = '{e: 64'd5, pp: 32'd9, k: 32'd5};
    vecs[3] = '{e: 64'd100, pp: 32'd13, k: 32'd9};
    vecs[4] = '{e: 64'h1234_5678_9ABC_DEF0, pp: 32'h0001_0000, k: 32'h0000_DEF0};
    vecs[5] = '{e: 64'h1234_5678_9ABC_DEF0, pp: 32'h8000_0000, k: 32'h1ABC_DEF0};

    // reset values
    #12;
    chk("rst_flags", 64'({start_ready, busy, key_valid, err, din_ready, dout_valid}), 64'(6'b100000));
    chk("rst_key", 64'(key_o), 64'(0));
    chk("rst_blk", 64'(blk_cnt), 64'(0));
    chk("rst_state", 64'(dbg_state), 64'(IDLE));
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) do_key(vecs[i].e, vecs[i].pp, vecs[i].k, $sformatf("vec%0d", i));

    for (int i = 0; i < 6; i++) begin
      e  = {$urandom, $urandom};
      pp = (i % 2 == 0) ? 32'($urandom_range(1, 1000)) : 32'($urandom);
      if (pp == '0) pp = 32'd1;
      do_key(e, pp, ref_mod(e, pp), $sformatf("rnd%0d", i));
    end

    // single word encrypt
    do_key(64'd100, 32'd7, 32'd2, "enc_key");
    @(negedge clk);
    din_valid = 1'b1;
    din_data  = 64'hFF;
    dout_ready = 1'b0;
    #1 chk("enc_din_ready", 64'(din_ready), 64'(1));
    @(negedge clk);
    din_valid = 1'b0;
    chk("enc_valid", 64'(dout_valid), 64'(1));
    chk("enc_data", dout_data, 64'hFD);
    chk("enc_blk", 64'(blk_cnt), 64'(1));

    // start refused while dout_valid is high
    @(negedge clk);
    start = 1'b1;
    exp_i = 64'd100;
    p_i   = 32'd13;
    #1 chk("block_start_ready", 64'(start_ready), 64'(0));
    @(negedge clk);
    start = 1'b0;
    chk("block_not_taken", 64'({busy, key_valid, dout_valid}), 64'(3'b011));
    dout_ready = 1'b1;
    @(negedge clk);
    dout_ready = 1'b0;
    chk("block_drain", 64'(dout_valid), 64'(0));

    // re-key while keyed
    do_key(64'd100, 32'd13, 32'd9, "rekey");

    // divide by zero, then recovery
    @(negedge clk);
    start = 1'b1;
    exp_i = 64'd123;
    p_i   = '0;
    @(negedge clk);
    start = 1'b0;
    din_valid = 1'b1;
    #1;
    chk("err_flags", 64'({err, busy, key_valid, din_ready, start_ready}), 64'(5'b10001));
    repeat (3) @(negedge clk);
    chk("err_sticky", 64'({err, busy}), 64'(2'b10));
    din_valid = 1'b0;
    do_key(64'd5, 32'd9, 32'd5, "err_recover");

    // streams against the scoreboard
    e  = {$urandom, $urandom};
    pp = $urandom;
    if (pp == '0) pp = 32'd3;
    do_key(e, pp, ref_mod(e, pp), "strm_key");
    do_stream(1'b1, 8, ref_mod(e, pp), 8, "strm_toggle");
    do_stream(1'b0, 10, ref_mod(e, pp), 18, "strm_full");

    // reset mid-reduction
    @(negedge clk);
    start = 1'b1;
    exp_i = {$urandom, $urandom};
    p_i   = 32'd77;
    @(negedge clk);
    start = 1'b0;
    repeat (29) @(negedge clk);
    chk("mid_busy", 64'(busy), 64'(1));
    rst = 1'b1;
    #1;
    chk("mid_rst_flags", 64'({start_ready, busy, key_valid, err, din_ready, dout_valid}), 64'(6'b100000));
    chk("mid_rst_key", 64'(key_o), 64'(0));
    chk("mid_rst_blk", 64'(blk_cnt), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    e  = {$urandom, $urandom};
    pp = $urandom;
    if (pp == '0) pp = 32'd5;
    do_key(e, pp, ref_mod(e, pp), "post_rst");

    chk("busy_keyvalid_overlap", 64'(overlap), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/enc_modxor_stream.md
# enc_modxor_stream

Parametrised key-derivation and stream-encryption block for the Diffie-Hellman datapath. Accepts the shared-secret exponent result `exp` and prime `p`, and reduces `exp mod p` with a bit-serial restoring divider instead of a combinational divide. It then holds the resulting key and XOR-encrypts an arbitrary number of data words over a valid/ready stream. It sits after the modular-exponentiation stage and feeds the ciphertext sink.

## Interface
- `DW`, 64, width of `exp`, data words and ciphertext
- `MW`, 32, width of modulus `p` and key; `MW <= DW`
- `CW`, 16, width of the encrypted-word counter
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `start`  in  1  request key derivation; accepted when `start_ready`
- `start_ready`  out  1  high in IDLE, ERR, or KEYED with `dout_valid==0`
- `exp`  in  DW  dividend, sampled on accepted `start`
- `p`  in  MW  modulus, sampled on accepted `start`
- `busy`  out  1  high while in REDUCE
- `key_valid`  out  1  high in KEYED
- `key_o`  out  MW  `exp mod p`; valid while `key_valid`
- `err`  out  1  sticky divide-by-zero flag, cleared by next accepted `start`
- `din_valid` / `din_ready`  in/out  1  plaintext handshake
- `din_data`  in  DW  plaintext word (the old `r2`)
- `dout_valid` / `dout_ready`  out/in  1  ciphertext handshake
- `dout_data`  out  DW  ciphertext (the old `c1`)
- `blk_cnt`  out  CW  words encrypted since last key load, wraps modulo 2^CW

## Operation
- States: IDLE, REDUCE, KEYED, ERR.
- IDLE: waits for `start`. If `p==0` at acceptance, go to ERR with `err=1`. Otherwise load `exp` into the shift register, clear the remainder and counter, clear `err`, and go to REDUCE.
- REDUCE: one iteration per cycle for DW cycles.
  - Remainder register is MW+1 bits: `rem = {rem[MW-1:0], sh[DW-1]}`, `sh <<= 1`.
  - If `rem >= p`, then `rem -= p`.
  - On the final iteration, load `key_o = rem[MW-1:0]`, clear `blk_cnt`, and go to KEYED.
  - `start` is not accepted in REDUCE.
- KEYED:
  - `din_ready = !dout_valid || dout_ready` (single output register).
  - On a `din` handshake: `dout_data = din_data ^ {{(DW-MW){1'b0}}, key_o}`, `dout_valid=1`, `blk_cnt += 1`.
  - `dout_valid` clears on `dout_ready` unless a new word is loaded in the same cycle.
  - An accepted `start` (only when `dout_valid==0`) drops `key_valid` and `din_ready` and re-enters the IDLE acceptance path: REDUCE, or ERR if `p==0`.
- ERR: `key_valid=0`, `din_ready=0`. Exits only on accepted `start`.
- `din_ready` is 0 in every state except KEYED.
- Arithmetic: remainder compare and subtract are MW+1 bits wide. No truncation occurs before the subtract.

## Timing
- Reset value of all outputs is 0, except `start_ready=1`. State is IDLE.
- `start` accepted at edge E0 → `busy=1` after E0 → key loaded at edge E_DW. `key_valid=1` DW cycles after acceptance (64 at defaults). `busy` and `key_valid` are never both high.
- `p==0` → `err=1` the cycle after acceptance. `busy` never asserts.
- Encryption latency is 1 cycle from `din` handshake to `dout_valid`. Throughput is 1 word/cycle when `dout_ready` is held high.
- Simultaneous `dout_ready` and `din_valid` with `dout_valid=1`: the old word retires and the new word loads in the same edge.
- `blk_cnt` wraps from 2^CW-1 to 0 without any flag.
- `rst` mid-REDUCE or mid-stream aborts immediately. The next `start` restarts cleanly.
- `exp`, `p` and `din_data` may change freely after their handshake.

## Structure
- Package `enc_pkg` holds:
  - `state_t` enum (IDLE, REDUCE, KEYED, ERR)
  - default width constants `ENC_DW=64`, `ENC_MW=32`, `ENC_CW=16`
- Sub-module `mod_reduce_seq` is the bit-serial restoring reducer.
  - Ports: `clk`, `rst`, `load`, `exp`, `p`, `done`, `rem`.
  - `enc_modxor_stream` owns the FSM, key register, output register and counter.

## Test plan
- `exp=100`, `p=7` → `key_o=2` exactly 64 cycles after `start`. `din_data=0xFF` → `dout_data=0xFD`, `blk_cnt=1`.
- `exp=2^64-1`, `p=0xFFFFFFFF` → `key_o=0`. `exp=5`, `p=9` → `key_o=5`.
- `p=0` → `err=1` next cycle, `busy` stays 0, `din_ready=0`. A following valid `start` clears `err`.
- Stream 8 words with `dout_ready` toggling 1010… → no word lost or duplicated, every output equals `din^key`, `blk_cnt=8`.
- Re-key in KEYED (`exp=100`, `p=13`) → `key_valid` drops, then `key_o=9` after 64 cycles and `blk_cnt=0`. `start` while `dout_valid=1` is not accepted.
- Assert `rst` at cycle 30 of REDUCE → all outputs return to reset values. A new `start` yields the correct key after 64 cycles.
